// File: rtl/axi_wr_master_mo.sv
// -----------------------------------------------------------------------------
// axi_wr_master_mo
//
// AXI4 write-channel master with up to MAX_OUT bursts outstanding.
// User commands are registered onto AW, user beats pass through to W with
// wlast generated from a per-burst beat counter, and each B response is
// returned to the user as bresp_out plus a one-cycle bdone pulse.
//
// Ports
//   clk, resetn                      clock, asynchronous active-low reset
//   awaddr_in/awlen_in/awsize_in/
//   awburst_in/awvalid_in/awready_out  user burst command
//   wdata_in/wstrb_in/wvalid_in/
//   wready_out                       user write beats
//   bready_in/bresp_out/bdone        user response side
//   outstanding                      bursts accepted but not yet B-acknowledged
//   axi_aw*/axi_w*/axi_b*            AXI4 AW, W and B channels
//
// Optional build macro WR_ERR_STICKY_EN adds err_clr (in) and err_sticky
// (out): a sticky SLVERR/DECERR flag that blocks new commands until cleared.
// -----------------------------------------------------------------------------
module axi_wr_master_mo #(
    parameter int AW      = 32,
    parameter int DW      = 64,
    parameter int MAX_OUT = 4
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [AW-1:0]                 awaddr_in,
    input  logic [7:0]                    awlen_in,
    input  logic [2:0]                    awsize_in,
    input  logic [1:0]                    awburst_in,
    input  logic                          awvalid_in,
    output logic                          awready_out,
    input  logic [DW-1:0]                 wdata_in,
    input  logic [DW/8-1:0]               wstrb_in,
    input  logic                          wvalid_in,
    output logic                          wready_out,
    input  logic                          bready_in,
    output logic [1:0]                    bresp_out,
    output logic                          bdone,
    output logic [$clog2(MAX_OUT+1)-1:0]  outstanding,
`ifdef WR_ERR_STICKY_EN
    input  logic                          err_clr,
    output logic                          err_sticky,
`endif
    output logic [AW-1:0]                 axi_awaddr,
    output logic [7:0]                    axi_awlen,
    output logic [2:0]                    axi_awsize,
    output logic [1:0]                    axi_awburst,
    output logic                          axi_awvalid,
    input  logic                          axi_awready,
    output logic [DW-1:0]                 axi_wdata,
    output logic [DW/8-1:0]               axi_wstrb,
    output logic                          axi_wlast,
    output logic                          axi_wvalid,
    input  logic                          axi_wready,
    input  logic [1:0]                    axi_bresp,
    input  logic                          axi_bvalid,
    output logic                          axi_bready
);

    localparam int CW = $clog2(MAX_OUT + 1);
    localparam int PW = $clog2(MAX_OUT);

    typedef enum logic {W_IDLE, W_DATA} w_state_t;

    w_state_t       state, state_nxt;
    logic [7:0]     beat_cnt;
    logic           run_q;
    logic           aw_accept, b_hs, w_hs, pop, err_block;

    logic [7:0]     len_mem [MAX_OUT];
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  fifo_cnt;
    logic           fifo_empty, fifo_full;

    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == CW'(MAX_OUT));

`ifdef WR_ERR_STICKY_EN
    assign err_block = err_sticky;
`else
    assign err_block = 1'b0;
`endif

    // run_q holds awready_out low while reset is asserted so every output
    // reads 0 during reset.
    assign awready_out = run_q && !axi_awvalid && (outstanding < CW'(MAX_OUT))
                         && !fifo_full && !err_block;
    assign aw_accept   = awvalid_in && awready_out;
    assign axi_bready  = bready_in && (outstanding != '0);
    assign b_hs        = axi_bvalid && axi_bready;
    assign w_hs        = axi_wvalid && axi_wready;

    // AW register slice: one burst per two cycles since awvalid must drop
    // before the next command is accepted.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            run_q       <= 1'b0;
            axi_awvalid <= 1'b0;
            axi_awaddr  <= '0;
            axi_awlen   <= '0;
            axi_awsize  <= '0;
            axi_awburst <= '0;
        end else begin
            run_q <= 1'b1;
            if (aw_accept) begin
                axi_awvalid <= 1'b1;
                axi_awaddr  <= awaddr_in;
                axi_awlen   <= awlen_in;
                axi_awsize  <= awsize_in;
                axi_awburst <= awburst_in;
            end else if (axi_awvalid && axi_awready) begin
                axi_awvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            outstanding <= '0;
        end else begin
            case ({aw_accept, b_hs})
                2'b10:   outstanding <= outstanding + CW'(1);
                2'b01:   outstanding <= outstanding - CW'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    // NOTE: the length storage has no reset; entries are only read after
    // being written, and the pointers/count that define validity are reset.
    always_ff @(posedge clk) begin
        if (aw_accept) len_mem[wr_ptr] <= awlen_in;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (aw_accept) wr_ptr <= wr_ptr + PW'(1);
            if (pop)       rd_ptr <= rd_ptr + PW'(1);
            case ({aw_accept, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // W FSM: state register and beat counter. The counter is never
    // decremented on the last beat, so awlen=255 cannot wrap before wlast.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= W_IDLE;
            beat_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (pop)                      beat_cnt <= len_mem[rd_ptr];
            else if (w_hs && !axi_wlast)  beat_cnt <= beat_cnt - 8'd1;
        end
    end

    // Next state; popping on the last beat keeps W_DATA without a bubble.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            W_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = W_DATA;
                end
            end
            W_DATA: begin
                if (w_hs && axi_wlast) begin
                    if (!fifo_empty) pop = 1'b1;
                    else             state_nxt = W_IDLE;
                end
            end
            default: state_nxt = W_IDLE;
        endcase
    end

    // NOTE: every output gets a default before the case so no latch is
    // inferred for the W_IDLE path.
    always_comb begin
        axi_wdata  = '0;
        axi_wstrb  = '0;
        axi_wvalid = 1'b0;
        axi_wlast  = 1'b0;
        wready_out = 1'b0;
        if (state == W_DATA) begin
            axi_wdata  = wdata_in;
            axi_wstrb  = wstrb_in;
            axi_wvalid = wvalid_in;
            axi_wlast  = (beat_cnt == 8'd0);
            wready_out = axi_wready;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bresp_out <= '0;
            bdone     <= 1'b0;
        end else begin
            bdone <= b_hs;
            if (b_hs) bresp_out <= axi_bresp;
        end
    end

`ifdef WR_ERR_STICKY_EN
    // SLVERR/DECERR both have bresp[1] set; setting wins over clearing.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                    err_sticky <= 1'b0;
        else if (b_hs && axi_bresp[1])  err_sticky <= 1'b1;
        else if (err_clr)               err_sticky <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_axi_wr_master_mo.sv
// -----------------------------------------------------------------------------
// tb_axi_wr_master_mo
//
// Scoreboard bench for axi_wr_master_mo: stimulus tasks push expected AW
// payloads, W beats and B responses into queues; a monitor process pops and
// compares whenever the DUT presents a handshake or bdone. A small B-slave
// process returns one response per completed W burst, gated by b_credit.
// -----------------------------------------------------------------------------
module tb_axi_wr_master_mo;

    localparam int AW = 32;
    localparam int DW = 64;
    localparam int MAX_OUT = 4;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    len;
        logic [2:0]    size;
        logic [1:0]    burst;
    } aw_t;

    typedef struct packed {
        logic [DW-1:0]   data;
        logic [DW/8-1:0] strb;
        logic            last;
    } w_t;

    logic            clk, resetn;
    logic [AW-1:0]   awaddr_in;
    logic [7:0]      awlen_in;
    logic [2:0]      awsize_in;
    logic [1:0]      awburst_in;
    logic            awvalid_in, awready_out;
    logic [DW-1:0]   wdata_in;
    logic [DW/8-1:0] wstrb_in;
    logic            wvalid_in, wready_out;
    logic            bready_in;
    logic [1:0]      bresp_out;
    logic            bdone;
    logic [2:0]      outstanding;
    logic [AW-1:0]   axi_awaddr;
    logic [7:0]      axi_awlen;
    logic [2:0]      axi_awsize;
    logic [1:0]      axi_awburst;
    logic            axi_awvalid, axi_awready;
    logic [DW-1:0]   axi_wdata;
    logic [DW/8-1:0] axi_wstrb;
    logic            axi_wlast, axi_wvalid, axi_wready;
    logic [1:0]      axi_bresp;
    logic            axi_bvalid, axi_bready;
`ifdef WR_ERR_STICKY_EN
    logic            err_clr, err_sticky;
`endif

    axi_wr_master_mo #(.AW(AW), .DW(DW), .MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .resetn(resetn),
        .awaddr_in(awaddr_in), .awlen_in(awlen_in), .awsize_in(awsize_in),
        .awburst_in(awburst_in), .awvalid_in(awvalid_in), .awready_out(awready_out),
        .wdata_in(wdata_in), .wstrb_in(wstrb_in), .wvalid_in(wvalid_in),
        .wready_out(wready_out),
        .bready_in(bready_in), .bresp_out(bresp_out), .bdone(bdone),
        .outstanding(outstanding),
`ifdef WR_ERR_STICKY_EN
        .err_clr(err_clr), .err_sticky(err_sticky),
`endif
        .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
        .axi_awburst(axi_awburst), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int w_beats = 0;
    int w_first_cyc = -1;
    int w_last_cyc = -1;
    int b_done_cnt = 0;
    int b_pending = 0;
    int b_credit = 1000;

    aw_t        exp_aw[$];
    w_t         exp_w[$];
    logic [1:0] exp_b[$];
    logic [1:0] b_codes[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk_data(input logic [15:0] tag, input int i);
        return {tag, 16'hA5C3, 32'(i) ^ 32'h1234_0000};
    endfunction

    function automatic logic [DW/8-1:0] mk_strb(input int i);
        return 8'hFF >> (i % 8);
    endfunction

    // Monitor / scoreboard: all samples on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (resetn) begin
                if (axi_awvalid && axi_awready) begin
                    if (exp_aw.size() == 0) check("aw_unexpected", 1, 0);
                    else check("aw_payload", {axi_awaddr, axi_awlen, axi_awsize, axi_awburst},
                               exp_aw.pop_front());
                end
                if (axi_wvalid && axi_wready) begin
                    w_beats++;
                    if (w_first_cyc < 0) w_first_cyc = cyc;
                    w_last_cyc = cyc;
                    if (exp_w.size() == 0) check("w_unexpected", 1, 0);
                    else check("w_beat", {axi_wdata, axi_wstrb, axi_wlast}, exp_w.pop_front());
                    if (axi_wlast) b_pending++;
                end
                if (bdone) begin
                    b_done_cnt++;
                    if (exp_b.size() == 0) check("b_unexpected", 1, 0);
                    else check("b_resp", bresp_out, exp_b.pop_front());
                end
            end
        end
    end

    // B slave: one response per completed W burst, limited by b_credit.
    initial begin
        logic hs;
        axi_bvalid = 1'b0;
        axi_bresp  = 2'b00;
        forever begin
            @(negedge clk);
            hs = axi_bvalid && axi_bready;
            @(posedge clk);
            #1;
            if (!resetn) begin
                axi_bvalid = 1'b0;
            end else begin
                if (hs) axi_bvalid = 1'b0;
                if (!axi_bvalid && b_credit > 0 && b_pending > 0 && b_codes.size() > 0) begin
                    axi_bvalid = 1'b1;
                    axi_bresp  = b_codes.pop_front();
                    b_pending--;
                    b_credit--;
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send_cmd(input logic [AW-1:0] a, input logic [7:0] l, input logic [1:0] resp);
        int t = 0;
        logic hs = 1'b0;
        exp_aw.push_back('{addr: a, len: l, size: 3'd3, burst: 2'b01});
        exp_b.push_back(resp);
        b_codes.push_back(resp);
        awaddr_in  = a;
        awlen_in   = l;
        awsize_in  = 3'd3;
        awburst_in = 2'b01;
        awvalid_in = 1'b1;
        do begin
            @(negedge clk);
            hs = awready_out;
            @(posedge clk);
            #1;
            t++;
        end while (!hs && t < 200);
        awvalid_in = 1'b0;
        if (!hs) check("aw_accept_timeout", 0, 1);
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic [DW/8-1:0] s);
        int t = 0;
        logic hs = 1'b0;
        wdata_in  = d;
        wstrb_in  = s;
        wvalid_in = 1'b1;
        do begin
            @(negedge clk);
            hs = wready_out;
            @(posedge clk);
            #1;
            t++;
        end while (!hs && t < 200);
        wvalid_in = 1'b0;
        if (!hs) check("w_accept_timeout", 0, 1);
    endtask

    task automatic send_burst(input int len, input logic [15:0] tag);
        for (int i = 0; i <= len; i++) begin
            exp_w.push_back('{data: mk_data(tag, i), strb: mk_strb(i), last: (i == len)});
            send_beat(mk_data(tag, i), mk_strb(i));
        end
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while ((exp_aw.size() != 0 || exp_w.size() != 0 || exp_b.size() != 0 ||
                outstanding != 0) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check(name, (exp_aw.size() == 0 && exp_w.size() == 0 && exp_b.size() == 0 &&
                     outstanding == 0), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_bdone(input string name);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!bdone && t < 200);
        if (!bdone) check(name, 0, 1);
    endtask

    function automatic logic [255:0] all_outputs();
        return {awready_out, wready_out, bresp_out, bdone, outstanding,
                axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awvalid,
                axi_wdata, axi_wstrb, axi_wlast, axi_wvalid, axi_bready};
    endfunction

    initial begin
        resetn      = 1'b1;
        awaddr_in   = '0;
        awlen_in    = '0;
        awsize_in   = '0;
        awburst_in  = '0;
        awvalid_in  = 1'b0;
        wdata_in    = '0;
        wstrb_in    = '0;
        wvalid_in   = 1'b0;
        bready_in   = 1'b1;
        axi_awready = 1'b1;
        axi_wready  = 1'b1;
`ifdef WR_ERR_STICKY_EN
        err_clr     = 1'b0;
`endif
        #2 resetn = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", all_outputs(), 0);
        @(posedge clk);
        #1 resetn = 1'b1;
        repeat (2) begin @(posedge clk); #1; end

        // 1: single len-3 burst, awvalid one cycle after accept.
        b_done_cnt = 0;
        send_cmd(32'h1000, 8'd3, 2'b00);
        @(negedge clk);
        check("aw_latency", axi_awvalid, 1);
        @(posedge clk);
        #1;
        send_burst(3, 16'h0001);
        wait_idle("single_drain");
        check("single_bdone_count", b_done_cnt, 1);

        // 2: len 0 then len 255 queued, W stream must have no bubble.
        send_cmd(32'h2000, 8'd0, 2'b01);
        send_cmd(32'h3000, 8'd255, 2'b00);
        w_first_cyc = -1;
        w_beats = 0;
        send_burst(0, 16'h0002);
        send_burst(255, 16'h0003);
        wait_idle("b2b_drain");
        check("b2b_beats", w_beats, 257);
        check("b2b_no_bubble", w_last_cyc - w_first_cyc, 256);

        // 3: fill to MAX_OUT with B held off.
        b_credit = 0;
        for (int i = 0; i < MAX_OUT; i++) begin
            send_cmd(32'h4000 + 32'(i) * 32'h100, 8'd0, 2'b00);
            send_burst(0, 16'h0010 + 16'(i));
        end
        @(negedge clk);
        check("full_outstanding", outstanding, 4);
        check("full_awready", awready_out, 0);
        @(posedge clk);
        #1 b_credit = 1;
        wait_bdone("full_bdone_timeout");
        check("after_b_outstanding", outstanding, 3);
        check("after_b_awready", awready_out, 1);
        b_credit = 1000;
        wait_idle("full_drain");

        // 4: simultaneous AW accept and B handshake at outstanding 2.
        b_credit = 0;
        send_cmd(32'h5000, 8'd0, 2'b01);
        send_burst(0, 16'h0020);
        send_cmd(32'h5100, 8'd0, 2'b00);
        send_burst(0, 16'h0021);
        @(negedge clk);
        check("pre_sim_outstanding", outstanding, 2);
        @(posedge clk);
        #2 b_credit = 1;
        @(posedge clk);
        #1;
        exp_aw.push_back('{addr: 32'h5200, len: 8'd0, size: 3'd3, burst: 2'b01});
        exp_b.push_back(2'b00);
        b_codes.push_back(2'b00);
        awaddr_in  = 32'h5200;
        awlen_in   = 8'd0;
        awvalid_in = 1'b1;
        @(negedge clk);
        check("sim_both_handshake", {awready_out, axi_bvalid && axi_bready}, 2'b11);
        @(posedge clk);
        #1 awvalid_in = 1'b0;
        @(negedge clk);
        check("sim_outstanding", outstanding, 2);
        check("sim_bdone", bdone, 1);
        @(posedge clk);
        #1;
        send_burst(0, 16'h0022);
        b_credit = 1000;
        wait_idle("sim_drain");

        // 5: async reset during beat 2 of a len-7 burst.
        send_cmd(32'h6000, 8'd7, 2'b00);
        exp_w.push_back('{data: mk_data(16'h0030, 0), strb: mk_strb(0), last: 1'b0});
        exp_w.push_back('{data: mk_data(16'h0030, 1), strb: mk_strb(1), last: 1'b0});
        send_beat(mk_data(16'h0030, 0), mk_strb(0));
        wdata_in  = mk_data(16'h0030, 1);
        wstrb_in  = mk_strb(1);
        wvalid_in = 1'b1;
        @(negedge clk);
        #1 resetn = 1'b0;
        #1;
        check("midburst_reset_outputs", all_outputs(), 0);
        wvalid_in = 1'b0;
        exp_aw.delete();
        exp_w.delete();
        exp_b.delete();
        b_codes.delete();
        b_pending = 0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        w_beats = 0;
        send_cmd(32'h7000, 8'd1, 2'b00);
        send_burst(1, 16'h0040);
        wait_idle("post_reset_drain");
        check("post_reset_beats", w_beats, 2);

        // 6: error response propagates to bresp_out (and the sticky flag).
        send_cmd(32'h8000, 8'd0, 2'b10);
        send_burst(0, 16'h0050);
        wait_bdone("err_bdone_timeout");
`ifdef WR_ERR_STICKY_EN
        check("err_sticky_set", err_sticky, 1);
        check("err_blocks_awready", awready_out, 0);
        @(posedge clk);
        #1 err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
        @(negedge clk);
        check("err_sticky_clr", err_sticky, 0);
        check("err_awready_back", awready_out, 1);
`endif
        wait_idle("final_drain");
        check("final_bresp", bresp_out, 2'b10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        check("global_timeout", 0, 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
